// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame link.
// Used by both the frame receiver and the frame transmitter.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int DATA_BITS_DEF  = 8;
  localparam int BIT_CYCLES_DEF = 4;

endpackage

// File: rtl/serial_frame_rx_bit_timer.sv
// Modulo bit-period counter with synchronous clear.
// Pulses sample at mid-bit, half a period after clear, then once per bit.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic sample
);

  localparam int TW   = $clog2(BIT_CYCLES);
  localparam int HALF = BIT_CYCLES / 2;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == TW'(BIT_CYCLES - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample = (cnt_q == TW'(HALF - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, LSB-first data, even parity, stop.
// Completed frames land in a valid/ready output register one cycle later.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic                 C,
  input  logic                 RST_N,
  input  logic                 SER_IN,
  input  logic                 OUT_READY,
  output logic                 OUT_VALID,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic                 OUT_PERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN
);

  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [2:0] IDLE      = S_IDLE;
  localparam logic [2:0] START     = S_START;
  localparam logic [2:0] DATA      = S_DATA;
  localparam logic [2:0] PARITY    = S_PARITY;
  localparam logic [2:0] STOP      = S_STOP;
  localparam logic [2:0] WAIT_HIGH = S_WAIT_HIGH;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 acc_q, acc_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_perr_q, out_perr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 tmr_clr;
  logic                 sample;
  logic [DATA_BITS-1:0] msb_bit;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk   (C),
    .rst_n (RST_N),
    .clr   (tmr_clr),
    .sample(sample)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    par_d   = par_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    tmr_clr = 1'b0;
    msb_bit = '0;
    msb_bit[DATA_BITS-1] = SER_IN;
    unique case (state_q)
      IDLE: begin
        if (!SER_IN) begin
          state_d = START;
          tmr_clr = 1'b1;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          state_d = SER_IN ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          sh_d  = (sh_q >> 1) | msb_bit;
          acc_d = acc_q ^ SER_IN;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          par_d   = SER_IN;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (SER_IN) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (SER_IN) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A held byte drains on a transfer; a pending frame needs a free slot.
  always_comb begin
    out_valid_d = out_valid_q & ~OUT_READY;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    frame_err_d = ferr_q;
    overrun_d   = 1'b0;
    if (done_q) begin
      if (!out_valid_q || OUT_READY) begin
        out_valid_d = 1'b1;
        out_data_d  = sh_q;
        out_perr_d  = par_q ^ acc_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge C) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      acc_q       <= 1'b0;
      par_q       <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      par_q       <= par_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_PERR  = out_perr_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx, 8 data bits, 4 cycles per bit.
// Frame vectors from a table plus hand-built corner sequences.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       ser_in;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_perr;
  logic       frame_err;
  logic       overrun;

  int checks;
  int errors;

  serial_frame_rx #(
    .DATA_BITS (8),
    .BIT_CYCLES(4)
  ) dut (
    .C        (clk),
    .RST_N    (rst_n),
    .SER_IN   (ser_in),
    .OUT_READY(out_ready),
    .OUT_VALID(out_valid),
    .OUT_DATA (out_data),
    .OUT_PERR (out_perr),
    .FRAME_ERR(frame_err),
    .OVERRUN  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       rdy;
    logic       perr;
    logic       v_next;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after t0+43.
  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      ser_in = bits[k];
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic quiet(input string name, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid || frame_err || overrun) hits++;
    end
    chk(name, 16'(hits), 16'd0);
  endtask

  initial begin
    logic [10:0] bits;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    ser_in    = 1'b1;
    out_ready = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h6B, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data",  16'(out_data),  16'd0);
    chk("rst_perr",  16'(out_perr),  16'd0);
    chk("rst_ferr",  16'(frame_err), 16'd0);
    chk("rst_ovr",   16'(overrun),   16'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      out_ready = vecs[i].rdy;
      send_frame(vecs[i].data, vecs[i].par, 1'b1);
      chk("tbl_valid", 16'(out_valid), 16'd1);
      chk("tbl_data", 16'(out_data), 16'(vecs[i].data));
      chk("tbl_perr", 16'(out_perr), 16'(vecs[i].perr));
      chk("tbl_ferr", 16'(frame_err), 16'd0);
      chk("tbl_ovr", 16'(overrun), 16'd0);
      @(negedge clk);
      chk("tbl_valid_next", 16'(out_valid),
          16'(vecs[i].v_next));
      chk("tbl_hold_data", 16'(out_data),
          16'(vecs[i].data));
      out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_drained", 16'(out_valid), 16'd0);
      repeat (2) @(negedge clk);
    end

    out_ready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0);
    chk("ferr_pulse", 16'(frame_err), 16'd1);
    chk("ferr_valid", 16'(out_valid), 16'd0);
    ser_in = 1'b0;
    @(negedge clk);
    chk("ferr_one_cycle", 16'(frame_err), 16'd0);
    quiet("ferr_low_quiet", 9);
    ser_in = 1'b1;
    quiet("ferr_after_high", 60);

    ser_in = 1'b0;
    @(negedge clk);
    ser_in = 1'b1;
    quiet("glitch_quiet", 60);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("post_glitch_valid", 16'(out_valid), 16'd1);
    chk("post_glitch_data", 16'(out_data), 16'h5A);
    repeat (3) @(negedge clk);

    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    chk("b2b_first_valid", 16'(out_valid), 16'd1);
    chk("b2b_first_data", 16'(out_data), 16'h11);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("b2b_ovr_pulse", 16'(overrun), 16'd1);
    chk("b2b_keep_data", 16'(out_data), 16'h11);
    chk("b2b_keep_valid", 16'(out_valid), 16'd1);
    @(negedge clk);
    chk("b2b_ovr_once", 16'(overrun), 16'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_drain", 16'(out_valid), 16'd0);
    repeat (3) @(negedge clk);

    send_frame(8'h77, 1'b1, 1'b1);
    chk("pre_rst_valid", 16'(out_valid), 16'd1);
    chk("pre_rst_data", 16'(out_data), 16'h77);
    bits = {1'b1, 1'b0, 8'h99, 1'b0};
    for (int c = 0; c <= 20; c++) begin
      ser_in = bits[c / 4];
      if (c == 20) rst_n = 1'b0;
      @(negedge clk);
    end
    rst_n  = 1'b1;
    ser_in = 1'b1;
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_data", 16'(out_data), 16'd0);
    chk("mid_rst_perr", 16'(out_perr), 16'd0);
    chk("mid_rst_ferr", 16'(frame_err), 16'd0);
    chk("mid_rst_ovr", 16'(overrun), 16'd0);
    out_ready = 1'b1;
    quiet("mid_rst_quiet", 60);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
